mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 11 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder backing-memory slice.
package mem_responder_pkg;
    localparam int MEM_STATE_WIDTH = 2;
    localparam int MEM_LAT_WIDTH   = 8;

    typedef enum logic [MEM_STATE_WIDTH-1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, read-first, no reset on contents or read port.
module mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);
    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[idx_i] <= wdata_i;
        rdata_o <= mem[idx_i];
    end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory behind the cache's memory port (IDLE/BUSY/DONE handshake).
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write access counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        busy_o
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
`endif
);
    localparam logic [MEM_LAT_WIDTH-1:0] LAT_LOAD = MEM_LAT_WIDTH'(LATENCY - 1);

    mem_state_e             state_q, state_d;
    logic [MEM_LAT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  idx_q;
    logic [31:0]            wdata_q;
    logic                   accept;
    logic                   access;
    logic [ADDR_WIDTH-1:0]  addr_idx;
    logic [ADDR_WIDTH-1:0]  arr_idx;
    logic [31:0]            arr_rdata;
    logic                   unused_addr;

    assign addr_idx    = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        ready_o = 1'b0;
        busy_o  = (state_q != IDLE);
        case (state_q)
            IDLE: if (req_i) begin
                accept  = 1'b1;
                cnt_d   = LAT_LOAD;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == '0) begin
                access  = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                idx_q   <= addr_idx;
                wdata_q <= wdata_i;
            end
            if (access && !we_q) rdata_o <= arr_rdata;
        end
    end

    // The RAM reads every cycle; steering the live address while idle means its
    // output already holds array[index] by the access edge, even for LATENCY=1.
    // The previous write landed at least two edges before any new accept.
    assign arr_idx = (state_q == IDLE) ? addr_idx : idx_q;

    mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk_i   (clk_i),
        .we_i    (access && we_q),
        .idx_i   (arr_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (access && !we_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (access &&  we_q && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_WIDTH=10, LATENCY=4); stats checks when MEM_RESPONDER_STATS_EN is set.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o, busy_o;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count_o, wr_count_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ready_o (ready_o),
        .busy_o  (busy_o)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .rd_count_o (rd_count_o),
        .wr_count_o (wr_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one transaction, wait (bounded) for ready; returns at the negedge of the ready cycle.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd);
        int n;
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        @(posedge clk);
        #1 req_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_o !== 1'b1 && n < 20);
        chk({tag, "_lat"}, n, 5);
        rd = rdata_o;
    endtask

    initial begin
        logic [31:0] rd;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  busy_o,  0);
        chk("rst_ready", ready_o, 0);
        chk("rst_rdata", rdata_o, 0);
        @(negedge clk) rst_ni = 1'b1;

        // Write DEADBEEF to index 4, tracking busy/ready cycle by cycle.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0010; wdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_i = 1'b0; wdata_i = 32'h0; addr_i = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("wr_busy%0d", i),  busy_o,  (i <= 4) ? 1 : 0);
            chk($sformatf("wr_ready%0d", i), ready_o, (i == 4) ? 1 : 0);
        end

        // Read back, then hold.
        txn("rd10", 1'b0, 32'h0000_0010, 32'h0, rd);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        chk("rd10_hold", rdata_o, 32'hDEAD_BEEF);

        // Alias: upper and low address bits ignored.
        txn("alias", 1'b0, 32'h0000_1013, 32'h0, rd);
        chk("alias_data", rd, 32'hDEAD_BEEF);

        // Continuous request: only accepts at edges 0, 6, 12.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'(16) << 2; wdata_i = 32'hA000_0000;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_busy%0d", k),  busy_o,  (k % 6 != 5) ? 1 : 0);
            chk($sformatf("hold_ready%0d", k), ready_o, (k % 6 == 4) ? 1 : 0);
            addr_i  = 32'(16 + k + 1) << 2;
            wdata_i = 32'hA000_0000 + 32'(k + 1);
        end
        req_i = 1'b0;
        txn("hold_rd16", 1'b0, 32'(16) << 2, 32'h0, rd);
        chk("hold_d16", rd, 32'hA000_0000);
        txn("hold_rd22", 1'b0, 32'(22) << 2, 32'h0, rd);
        chk("hold_d22", rd, 32'hA000_0006);
        txn("hold_rd28", 1'b0, 32'(28) << 2, 32'h0, rd);
        chk("hold_d28", rd, 32'hA000_000C);

        // Reset during a pending write must not commit it.
        txn("pre8", 1'b1, 32'h0000_0020, 32'h5555_AAAA, rd);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; wdata_i = 32'h1234_5678;
        @(posedge clk);
        #1 req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_busy",  busy_o,  0);
        chk("mid_ready", ready_o, 0);
        chk("mid_rdata", rdata_o, 0);
        @(negedge clk) rst_ni = 1'b1;
        txn("post8", 1'b0, 32'h0000_0020, 32'h0, rd);
        chk("post8_data", rd, 32'h5555_AAAA);

`ifdef MEM_RESPONDER_STATS_EN
        // One read since reset; add two reads and two writes.
        txn("st_w0", 1'b1, 32'h0000_0040, 32'h0000_0011, rd);
        txn("st_w1", 1'b1, 32'h0000_0044, 32'h0000_0022, rd);
        txn("st_r0", 1'b0, 32'h0000_0040, 32'h0, rd);
        chk("st_r0_data", rd, 32'h0000_0011);
        txn("st_r1", 1'b0, 32'h0000_0044, 32'h0, rd);
        chk("st_r1_data", rd, 32'h0000_0022);
        chk("st_rd_cnt", rd_count_o, 3);
        chk("st_wr_cnt", wr_count_o, 2);
        @(negedge clk);
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt_q;
        release dut.wr_cnt_q;
        txn("st_rsat", 1'b0, 32'h0000_0040, 32'h0, rd);
        txn("st_wsat", 1'b1, 32'h0000_0048, 32'h0000_0033, rd);
        chk("st_rd_sat", rd_count_o, 32'hFFFF_FFFF);
        chk("st_wr_sat", wr_count_o, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
